// File: rtl/irq_pkg.sv
// irq_pkg: shared encodings and constants for the interrupt controller
package irq_pkg;
  localparam int IRQ_MAX = 16;
  localparam logic IRQ_SEL_IF = 1'b0;
  localparam logic IRQ_SEL_IE = 1'b1;
  localparam logic [15:0] IRQ_NULL_VECTOR = 16'h0000;
  typedef enum logic {IRQ_IDLE, IRQ_DISPATCH} irq_state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder
module irq_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [3:0]         idx,
  output logic               any
);
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req[i]) idx = 4'(i);
  end
  assign any = |req;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: IF/IE registers, edge/level capture, priority dispatch with registered vector
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int                 NUM_IRQ    = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '1,
  parameter logic [15:0]        VEC_BASE   = 16'h0040,
  parameter int                 VEC_STRIDE = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_IRQ-1:0] CPU_IRQ_TRIG,
  input  logic               IME,
  input  logic               REG_WR,
  input  logic               REG_SEL,
  input  logic [NUM_IRQ-1:0] REG_WDATA,
  output logic [NUM_IRQ-1:0] REG_RDATA,
  input  logic               ACK_STB,
  output logic               IRQ_PENDING,
  output logic               IRQ_REQ,
  output logic [NUM_IRQ-1:0] CPU_IRQ_ACK,
  output logic [15:0]        VECTOR,
  output logic               VEC_VALID
);
  logic [NUM_IRQ-1:0] if_q, ie_q, trig_prev, set, if_base, ack_clr;
  logic [3:0] win;
  logic any, accept;
  irq_state_t state;
  // level channels ignore trig_prev, edge channels need a fresh 0->1
  assign set = CPU_IRQ_TRIG & ~(trig_prev & EDGE_MASK);
  assign if_base = (REG_WR && REG_SEL == IRQ_SEL_IF) ? REG_WDATA : if_q;
  assign accept = ACK_STB && state == IRQ_IDLE;
  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (.req(if_base & ie_q), .idx(win), .any(any));
  assign ack_clr = (accept && any) ? NUM_IRQ'(1) << win : '0;
  assign REG_RDATA = (REG_SEL == IRQ_SEL_IE) ? ie_q : if_q;
  assign IRQ_PENDING = |(if_q & ie_q);
  assign IRQ_REQ = IRQ_PENDING & IME;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      if_q <= '0;
      ie_q <= '0;
      trig_prev <= '0;
      state <= IRQ_IDLE;
      CPU_IRQ_ACK <= '0;
      VECTOR <= IRQ_NULL_VECTOR;
      VEC_VALID <= 1'b0;
    end else begin
      if_q <= (if_base & ~ack_clr) | set;
      ie_q <= (REG_WR && REG_SEL == IRQ_SEL_IE) ? REG_WDATA : ie_q;
      trig_prev <= CPU_IRQ_TRIG;
      state <= accept ? IRQ_DISPATCH : IRQ_IDLE;
      CPU_IRQ_ACK <= ack_clr;
      VECTOR <= (accept && any) ? VEC_BASE + 16'(win) * 16'(VEC_STRIDE) : IRQ_NULL_VECTOR;
      VEC_VALID <= accept;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized scoreboard bench for irq_ctrl against a channel-level reference model
module tb_irq_ctrl;
  localparam logic [7:0] EDGE = 8'hF7;
  logic CLK, RESET, IME, REG_WR, REG_SEL, ACK_STB, IRQ_PENDING, IRQ_REQ, VEC_VALID;
  logic [7:0] CPU_IRQ_TRIG, REG_WDATA, REG_RDATA, CPU_IRQ_ACK;
  logic [15:0] VECTOR;
  logic IME2, REG_WR2, REG_SEL2, ACK_STB2, IRQ_PENDING2, IRQ_REQ2, VEC_VALID2;
  logic [15:0] TRIG2, WDATA2, RDATA2, ACK2, VECTOR2;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_if, m_ie, m_prev;
  logic m_busy;
  logic [23:0] q[$];
  logic [31:0] q2[$];

  irq_ctrl #(.NUM_IRQ(8), .EDGE_MASK(EDGE)) dut (
    .CLK(CLK), .RESET(RESET), .CPU_IRQ_TRIG(CPU_IRQ_TRIG), .IME(IME), .REG_WR(REG_WR),
    .REG_SEL(REG_SEL), .REG_WDATA(REG_WDATA), .REG_RDATA(REG_RDATA), .ACK_STB(ACK_STB),
    .IRQ_PENDING(IRQ_PENDING), .IRQ_REQ(IRQ_REQ), .CPU_IRQ_ACK(CPU_IRQ_ACK),
    .VECTOR(VECTOR), .VEC_VALID(VEC_VALID));

  irq_ctrl #(.NUM_IRQ(16), .EDGE_MASK(16'hFFFF), .VEC_BASE(16'hFFF8), .VEC_STRIDE(8)) dut2 (
    .CLK(CLK), .RESET(RESET), .CPU_IRQ_TRIG(TRIG2), .IME(IME2), .REG_WR(REG_WR2),
    .REG_SEL(REG_SEL2), .REG_WDATA(WDATA2), .REG_RDATA(RDATA2), .ACK_STB(ACK_STB2),
    .IRQ_PENDING(IRQ_PENDING2), .IRQ_REQ(IRQ_REQ2), .CPU_IRQ_ACK(ACK2),
    .VECTOR(VECTOR2), .VEC_VALID(VEC_VALID2));

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  // one clock of stimulus; the model advances on the same edge as the DUT
  task automatic cyc(input logic [7:0] trig, input logic ime, input logic wr, input logic sel,
                     input logic [7:0] wd, input logic ack);
    logic [7:0] ifb, nif, nie;
    logic acc;
    int win;
    CPU_IRQ_TRIG = trig; IME = ime; REG_WR = wr; REG_SEL = sel; REG_WDATA = wd; ACK_STB = ack;
    ifb = (wr && !sel) ? wd : m_if;
    acc = ack && !m_busy;
    win = -1;
    if (acc)
      for (int i = 7; i >= 0; i--)
        if (ifb[i] && m_ie[i]) win = i;
    nif = ifb;
    if (win >= 0) nif[win] = 1'b0;
    for (int i = 0; i < 8; i++)
      if (trig[i] && (!EDGE[i] || !m_prev[i])) nif[i] = 1'b1;
    nie = (wr && sel) ? wd : m_ie;
    @(posedge CLK);
    m_if = nif; m_ie = nie; m_prev = trig; m_busy = acc;
    if (acc) q.push_back(win < 0 ? 24'h0 : {16'(32'h40 + win * 8), 8'(1 << win)});
    #1;
  endtask

  task automatic model_clear();
    m_if = 0; m_ie = 0; m_prev = 0; m_busy = 0;
    q.delete();
  endtask

  task automatic rst_now();
    RESET = 1;
    #1;
    chk("rst_valid", VEC_VALID, 0);
    chk("rst_ack", CPU_IRQ_ACK, 0);
    chk("rst_vector", VECTOR, 0);
    model_clear();
    #1 RESET = 0;
  endtask

  always @(negedge CLK) begin
    chk("rdata", REG_RDATA, REG_SEL ? m_ie : m_if);
    chk("pending", IRQ_PENDING, |(m_if & m_ie));
    chk("req", IRQ_REQ, IME && |(m_if & m_ie));
    if (VEC_VALID) begin
      chk("valid_expected", q.size(), 1);
      if (q.size() != 0) begin
        logic [23:0] e;
        e = q.pop_front();
        chk("vector", VECTOR, e[23:8]);
        chk("ack_onehot", CPU_IRQ_ACK, e[7:0]);
      end
    end else begin
      chk("missing_valid", q.size(), 0);
      chk("idle_vector", VECTOR, 0);
      chk("idle_ack", CPU_IRQ_ACK, 0);
    end
  end

  always @(negedge CLK) begin
    if (VEC_VALID2) begin
      chk("v2_expected", q2.size(), 1);
      if (q2.size() != 0) chk("v2_wrap", {VECTOR2, ACK2}, q2.pop_front());
    end else chk("v2_idle_vector", VECTOR2, 0);
  end

  initial begin
    RESET = 1; CPU_IRQ_TRIG = 8'hFF; IME = 0; REG_WR = 0; REG_SEL = 0; REG_WDATA = 0; ACK_STB = 0;
    TRIG2 = 0; IME2 = 0; REG_WR2 = 0; REG_SEL2 = 0; WDATA2 = 0; ACK_STB2 = 0;
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_if", REG_RDATA, 0);
    chk("reset_valid", VEC_VALID, 0);
    chk("reset_pending", IRQ_PENDING, 0);
    CPU_IRQ_TRIG = 0;
    RESET = 0;
    cyc(8'h00, 0, 1, 1, 8'h05, 0);
    cyc(8'h04, 0, 0, 0, 0, 0);
    cyc(8'h00, 0, 0, 0, 0, 0);
    cyc(8'h01, 0, 0, 0, 0, 0);
    cyc(8'h00, 0, 0, 0, 0, 0);
    chk("if_05", REG_RDATA, 8'h05);
    chk("req_ime0", IRQ_REQ, 0);
    cyc(8'h00, 1, 0, 0, 0, 0);
    chk("req_ime1", IRQ_REQ, 1);
    cyc(8'h00, 1, 0, 0, 0, 1);
    chk("vec_ch0", VECTOR, 16'h0040);
    chk("if_04", REG_RDATA, 8'h04);
    cyc(8'h00, 1, 0, 0, 0, 0);
    cyc(8'h00, 1, 0, 0, 0, 1);
    chk("vec_ch2", VECTOR, 16'h0050);
    cyc(8'h00, 0, 1, 1, 8'h0F, 0);
    cyc(8'h01, 0, 0, 0, 0, 0);
    cyc(8'h00, 0, 0, 0, 0, 0);
    cyc(8'h01, 0, 0, 0, 0, 1);
    cyc(8'h00, 0, 0, 0, 0, 0);
    chk("set_beats_ack", REG_RDATA, 8'h01);
    cyc(8'h08, 0, 0, 0, 0, 1);
    cyc(8'h08, 0, 0, 0, 0, 0);
    cyc(8'h08, 0, 0, 0, 0, 1);
    chk("level_vec", VECTOR, 16'h0058);
    cyc(8'h08, 0, 0, 0, 0, 0);
    chk("level_stays", REG_RDATA, 8'h08);
    cyc(8'h00, 0, 0, 0, 0, 1);
    cyc(8'h00, 0, 0, 0, 0, 1);
    cyc(8'h00, 0, 0, 0, 0, 0);
    chk("b2b_one_clear", REG_RDATA, 8'h00);
    cyc(8'h02, 0, 0, 0, 0, 0);
    cyc(8'h00, 0, 1, 0, 8'h00, 1);
    chk("null_vector", {VEC_VALID, VECTOR}, 17'h10000);
    cyc(8'h01, 0, 0, 0, 0, 0);
    cyc(8'h00, 0, 0, 0, 0, 1);
    rst_now();
    for (int i = 0; i < 600; i++) begin
      cyc(8'($urandom), 1'($urandom), ($urandom % 6) == 0, 1'($urandom), 8'($urandom),
          ($urandom % 3) == 0);
      if (i == 300 && VEC_VALID) rst_now();
    end
    cyc(8'h00, 0, 0, 0, 0, 0);
    cyc(8'h00, 0, 0, 0, 0, 0);
    TRIG2 = 16'h0002; REG_WR2 = 1; REG_SEL2 = 1; WDATA2 = 16'h0002;
    @(posedge CLK); #1;
    TRIG2 = 0; REG_WR2 = 0;
    @(posedge CLK); #1;
    ACK_STB2 = 1;
    @(posedge CLK);
    q2.push_back({16'h0000, 16'h0002});
    #1 ACK_STB2 = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("queue2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
